word_serializer: RTL and testbench
==================================

// Module: word_serializer
// PURPOSE
//  Parallel-to-serial front end for the bit-serial sequence detector path.
//  Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clk.
//  The output drives the detector's serial input bit directly.
//  A one-entry holding buffer allows gapless back-to-back frames.
// PARAMETERS
//  WIDTH     8   word width in bits (>=2)
//  IDLE_BIT  0   level driven on serial_bit when no frame is active
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-high reset
//  data_in      in   WIDTH  word to serialize
//  data_valid   in   1      data_in valid
//  data_ready   out  1      = !hold_full (combinational); transfer on valid&&ready at rising clk
//  serial_bit   out  1      registered serial output
//  bit_valid    out  1      registered; 1 while serial_bit carries a frame bit
//  frame_start  out  1      registered; 1 during the first (MSB) bit of each frame
//  busy         out  1      = bit_valid | hold_full
// BEHAVIOUR
//  - Reset (async, immediate): serial_bit=IDLE_BIT, bit_valid=0, frame_start=0, hold_full=0,
//    bit count=0, FSM=IDLE; data_ready=1 and busy=0 once hold_full clears.
//  - FSM: IDLE -> SHIFT on load. SHIFT stays while bits remain.
//    At the last bit, SHIFT -> SHIFT if a word is loadable, else -> IDLE.
//  - "Shifter free" = FSM IDLE, or emitting the last bit of the frame in this cycle.
//  - Load priority on an edge when the shifter is free:
//    1) hold buffer (if full), clearing hold_full unless a new word is accepted on the same edge;
//    2) otherwise the word being accepted on this edge (pass-through, bypassing hold).
//  - An accepted word not loaded on that edge goes to the hold buffer.
//  - Accept and hold-drain on the same edge: hold takes the new word; hold_full stays 1.
//  - Latency: word accepted at edge N with the shifter free -> MSB on serial_bit in cycle N+1.
//    Bit i (MSB=0) appears in cycle N+1+i.
//  - Back-to-back: next frame's MSB directly follows the previous frame's last bit (zero gap).
//  - bit_valid=1 for exactly the frame length per word.
//    When no frame is active: serial_bit=IDLE_BIT, bit_valid=0.
//  - Bit counter: 0..FRAME_LEN-1, wraps to 0 on reload; width $clog2(WIDTH+1).
//  - data_in is sampled only on the accepting edge; later changes do not affect the frame.
//  - data_valid while data_ready=0: word is not taken; the source must hold it (no drop, no overwrite).
//  - Reset mid-frame: frame is abandoned and the hold buffer is discarded.
//    No partial bits appear after reset deasserts.
// CONFIGURATION
//  WORD_SERIALIZER_PARITY_EN
//   defined:   FRAME_LEN=WIDTH+1. After the LSB, one even-parity bit (XOR of the word) is emitted
//              with bit_valid=1, frame_start=0. Back-to-back rules apply after the parity bit.
//   undefined: FRAME_LEN=WIDTH; no parity logic synthesized.
// TESTING
//  1 Reset, then check idle: serial_bit=IDLE_BIT, bit_valid=0, frame_start=0, data_ready=1, busy=0.
//  2 Single word 8'hA5 accepted at edge N -> serial_bit 1,0,1,0,0,1,0,1 in cycles N+1..N+8.
//    bit_valid=1 for those 8 cycles; frame_start only in N+1; then IDLE_BIT, bit_valid=0.
//  3 Words 8'hF0, 8'h0F, 8'hC3 presented with data_valid held high
//    -> 24 contiguous bits 11110000_00001111_11000011 with no bit_valid gap.
//    data_ready drops while hold is full; no word is lost or duplicated.
//  4 Assert reset at bit 3 of 8'hFF with hold=8'h55
//    -> outputs go to reset values immediately; after release, idle until the next word.
//    8'h55 is never emitted.
//  5 Feed 8'hB0 into the sequence detector via serial_bit
//    -> detector sees 1,0,1,1 and raises detected once. A following 8'h00 raises no detection.
//  6 With WORD_SERIALIZER_PARITY_EN: 8'h07 -> 9 bits 0,0,0,0,0,1,1,1,1 (parity=1).
//    8'h03 -> parity bit 0. Back-to-back frames are 9 bits with no gap.

Source files
------------

// File: rtl/word_serializer.sv
// MSB-first parallel-to-serial converter with a one-word holding buffer.
// Define WORD_SERIALIZER_PARITY_EN to append an even-parity bit per frame.
module word_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_bit,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state, w_next_state;
  logic [WIDTH-1:0] r_sh, w_sh_nx;
  logic [WIDTH-1:0] r_hold, w_hold_nx;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic             r_hold_full, w_hold_full_nx;
  logic             r_sbit, w_sbit_nx;
  logic             r_bv, w_bv_nx;
  logic             r_fs, w_fs_nx;
  logic             w_last, w_free, w_accept, w_load;
  logic [WIDTH-1:0] w_word;
`ifdef WORD_SERIALIZER_PARITY_EN
  logic             r_par, w_par_nx;
`endif

  assign w_accept = data_valid & ~r_hold_full;
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST);
  assign w_free   = (r_state == S_IDLE) | w_last;
  assign w_load   = w_free & (r_hold_full | w_accept);
  assign w_word   = r_hold_full ? r_hold : data_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (w_load) w_next_state = S_SHIFT;
      S_SHIFT: if (w_last && !w_load) w_next_state = S_IDLE;
    endcase
  end

  // A word accepted while the shifter is busy parks in the hold buffer.
  always_comb begin
    w_hold_nx      = r_hold;
    w_hold_full_nx = r_hold_full;
    if (w_accept && (r_hold_full || !w_free)) begin
      w_hold_nx      = data_in;
      w_hold_full_nx = 1'b1;
    end else if (w_free && r_hold_full) begin
      w_hold_full_nx = 1'b0;
    end
  end

  always_comb begin
    w_sh_nx   = r_sh;
    w_cnt_nx  = r_cnt;
    w_sbit_nx = IDLE_BIT;
    w_bv_nx   = 1'b0;
    w_fs_nx   = 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
    w_par_nx  = r_par;
`endif
    if (w_load) begin
      w_sh_nx   = w_word;
      w_cnt_nx  = '0;
      w_sbit_nx = w_word[WIDTH-1];
      w_bv_nx   = 1'b1;
      w_fs_nx   = 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
      w_par_nx  = ^w_word;
`endif
    end else if (r_state == S_SHIFT && !w_last) begin
      w_sh_nx   = r_sh << 1;
      w_cnt_nx  = r_cnt + CW'(1);
      w_sbit_nx = r_sh[WIDTH-2];
      w_bv_nx   = 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
      if (r_cnt == CW'(WIDTH - 1)) w_sbit_nx = r_par;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh        <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
      r_sbit      <= IDLE_BIT;
      r_bv        <= 1'b0;
      r_fs        <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_sh        <= w_sh_nx;
      r_hold      <= w_hold_nx;
      r_hold_full <= w_hold_full_nx;
      r_cnt       <= w_cnt_nx;
      r_sbit      <= w_sbit_nx;
      r_bv        <= w_bv_nx;
      r_fs        <= w_fs_nx;
`ifdef WORD_SERIALIZER_PARITY_EN
      r_par       <= w_par_nx;
`endif
    end
  end

  assign data_ready  = ~r_hold_full;
  assign serial_bit  = r_sbit;
  assign bit_valid   = r_bv;
  assign frame_start = r_fs;
  assign busy        = r_bv | r_hold_full;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: bit-queue reference model plus directed frames.
// Honours WORD_SERIALIZER_PARITY_EN the same way as the design.
module tb_word_serializer;
  localparam int   WIDTH    = 8;
  localparam logic IDLE_BIT = 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int L = WIDTH + 1;
`else
  localparam int L = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready, serial_bit, bit_valid, frame_start, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  word_serializer #(.WIDTH(WIDTH), .IDLE_BIT(IDLE_BIT)) dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready),
    .serial_bit(serial_bit), .bit_valid(bit_valid),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: the future output stream as a queue of bits; the head is
  // the current cycle's output, one entry is consumed per clock.
  logic mq[$];
  logic fq[$];
  logic m_acc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      fq.delete();
    end else begin
      m_acc = data_valid && (mq.size() <= L);
      if (mq.size() > 0) begin
        void'(mq.pop_front());
        void'(fq.pop_front());
      end
      if (m_acc) begin
        for (int i = WIDTH - 1; i >= 0; i--) begin
          mq.push_back(data_in[i]);
          fq.push_back(i == WIDTH - 1);
        end
`ifdef WORD_SERIALIZER_PARITY_EN
        mq.push_back(^data_in);
        fq.push_back(1'b0);
`endif
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] e, a;
    if (mq.size() > 0) e = {mq[0], 1'b1, fq[0], (mq.size() <= L), 1'b1};
    else               e = {IDLE_BIT, 1'b0, 1'b0, 1'b1, 1'b0};
    a = {serial_bit, bit_valid, frame_start, data_ready, busy};
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL cycle t=%0t {bit,bv,fs,rdy,busy}: got %b expected %b",
               $time, a, e);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] w);
    bit acc = 0;
    data_in    = w;
    data_valid = 1'b1;
    for (int k = 0; k < 60 && !acc; k++) begin
      @(negedge clk);
      acc = data_ready;
      @(posedge clk);
    end
    #1;
    data_valid = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic capture(input int n, output logic [31:0] bits,
                         output logic [31:0] fs, output bit gap);
    int w = 0;
    bits = '0;
    fs   = '0;
    gap  = 0;
    @(negedge clk);
    while (!bit_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!bit_valid) gap = 1;
    bits = {bits[30:0], serial_bit};
    fs   = {fs[30:0], frame_start};
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      if (!bit_valid) gap = 1;
      bits = {bits[30:0], serial_bit};
      fs   = {fs[30:0], frame_start};
    end
  endtask

  logic [31:0] got, gfs;
  bit          gap;
  logic [31:0] e_bits, e_fs;
  int          cnt_bv, cnt_hi, ndet;
  logic [3:0]  win;
  bit          rs;

  initial begin
    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset",
          {serial_bit, bit_valid, frame_start, data_ready, busy},
          {IDLE_BIT, 4'b0010});
    @(posedge clk); #1;

    // Single word A5
    fork
      send(8'hA5);
      capture(L, got, gfs, gap);
    join
`ifdef WORD_SERIALIZER_PARITY_EN
    e_bits = 32'h14A; e_fs = 32'h100;
`else
    e_bits = 32'hA5;  e_fs = 32'h80;
`endif
    check("a5_bits", got, e_bits);
    check("a5_fs", gfs, e_fs);
    check("a5_gap", 32'(gap), 0);
    @(negedge clk);
    check("a5_after_bv", {31'b0, bit_valid}, 0);
    @(posedge clk); #1;

    // Three words, valid held high
    fork
      begin send(8'hF0); send(8'h0F); send(8'hC3); end
      capture(3 * L, got, gfs, gap);
    join
`ifdef WORD_SERIALIZER_PARITY_EN
    e_bits = {5'b0, 8'hF0, 1'b0, 8'h0F, 1'b0, 8'hC3, 1'b0};
    e_fs   = {5'b0, 9'h100, 9'h100, 9'h100};
`else
    e_bits = 32'hF00FC3; e_fs = 32'h808080;
`endif
    check("b2b_bits", got, e_bits);
    check("b2b_fs", gfs, e_fs);
    check("b2b_gap", 32'(gap), 0);
    repeat (2 * L) @(posedge clk);
    #1;

    // Reset at bit 3 of FF with 55 held
    send(8'hFF);
    send(8'h55);
    @(posedge clk);
    @(posedge clk); #1;
    check("hold_full_ready", {31'b0, data_ready}, 0);
    check("hold_full_busy", {31'b0, busy}, 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_out",
          {serial_bit, bit_valid, frame_start, data_ready, busy},
          {IDLE_BIT, 4'b0010});
    @(posedge clk); #1 reset = 1'b0;
    cnt_bv = 0;
    cnt_hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (bit_valid) cnt_bv++;
      if (serial_bit !== IDLE_BIT) cnt_hi++;
    end
    check("post_reset_bv", cnt_bv, 0);
    check("post_reset_bits", cnt_hi, 0);
    @(posedge clk); #1;

    // B0 then 00: pattern 1011 appears once in the stream
    fork
      begin send(8'hB0); send(8'h00); end
      capture(2 * L, got, gfs, gap);
    join
    ndet = 0;
    win  = '0;
    for (int i = 2 * L - 1; i >= 0; i--) begin
      win = {win[2:0], got[i]};
      if (win == 4'b1011) ndet++;
    end
    check("b0_detect_count", ndet, 1);
    check("b0_gap", 32'(gap), 0);
    repeat (2 * L) @(posedge clk);
    #1;

    // 07 and 03 back to back (parity bits 1 and 0 when enabled)
    fork
      begin send(8'h07); send(8'h03); end
      capture(2 * L, got, gfs, gap);
    join
`ifdef WORD_SERIALIZER_PARITY_EN
    e_bits = {14'b0, 9'b000001111, 9'b000000110};
`else
    e_bits = 32'h0703;
`endif
    check("par_bits", got, e_bits);
    check("par_gap", 32'(gap), 0);
    repeat (2 * L) @(posedge clk);
    #1;

    // Random traffic, source holds word while not ready
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rs = data_ready;
      @(posedge clk); #1;
      if (data_valid && rs) data_valid = 1'b0;
      if (!data_valid) begin
        data_in = WIDTH'($urandom);
        if ($urandom_range(3) != 0) data_valid = 1'b1;
      end
      if (c == 1500) begin
        #2 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
      end
    end
    data_valid = 1'b0;
    repeat (3 * L) @(posedge clk);
    #1;
    check("drain_busy", {31'b0, busy}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
